morse_game_ctrl: RTL

Parametrised game-control FSM for the Morse trainer, generalising the fixed-difficulty controllers into one block with runtime-selectable level.
- Fetches target symbols from an external synchronous ROM, reconfigures the display/timer for each symbol, and checks user input against the target.
- Keeps an N-digit BCD score and a lives counter, and handles session logout.
- Sits between the login block, the symbol ROM, the round timer and the seven-segment score display.

---
 rtl/morse_game_pkg.sv | 30 +++
 rtl/bcd_score_counter.sv | 43 ++++
 rtl/morse_game_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/morse_game_pkg.sv
// Shared definitions for the Morse trainer game controller: FSM states,
// difficulty level codes and the per-level ROM base address.
package morse_game_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READY,
      S_FETCH,
      S_LATCH,
      S_SHOW,
      S_WAIT_IN,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [1:0] LVL_EASY = 2'd0;
   localparam logic [1:0] LVL_MED  = 2'd1;
   localparam logic [1:0] LVL_HARD = 2'd2;

   // Each level owns one quarter of the symbol ROM; level 3 gets the top quarter.
   function automatic int unsigned level_base(input logic [1:0] lvl, input int unsigned addr_w);
      return 32'(lvl) << (addr_w - 32'd2);
   endfunction

   // Codes 2 and 3 both play by hard-mode rules.
   function automatic logic is_hard(input logic [1:0] lvl);
      return lvl[1];
   endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Multi-digit BCD up-counter with synchronous clear; it sticks at all-9s
// instead of wrapping to zero.
module bcd_score_counter #(
   parameter int BCD_DIGITS = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    inc,
   output logic [4*BCD_DIGITS-1:0] score
);

   logic [4*BCD_DIGITS-1:0] score_d;

   always_comb begin
      logic carry;
      logic all_nine;
      // NOTE: every variable gets a value before any branch so no latch is inferred.
      score_d  = score;
      all_nine = 1'b1;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (score[4*i +: 4] != 4'd9) all_nine = 1'b0;
      end
      carry = inc && !all_nine;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (carry) begin
            if (score[4*i +: 4] == 4'd9) begin
               score_d[4*i +: 4] = 4'd0;
            end else begin
               score_d[4*i +: 4] = score[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      if (rst || clr) score <= '0;
      else            score <= score_d;
   end

endmodule

// File: rtl/morse_game_ctrl.sv
// Game-control FSM for the Morse trainer: fetches target symbols from an
// external synchronous ROM, checks user answers, keeps score and lives.
module morse_game_ctrl
   import morse_game_pkg::*;
#(
   parameter int NUM_W      = 4,
   parameter int ADDR_W     = 4,
   parameter int ROUNDS     = 10,
   parameter int BCD_DIGITS = 2,
   parameter int MAX_LIVES  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    logged_in,
   input  logic [1:0]              level,
   input  logic                    game_start,
   input  logic                    load,
   input  logic [NUM_W-1:0]        user_input,
   input  logic                    timeout,
   input  logic                    logout,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [NUM_W-1:0]        rom_data,
   output logic                    reconfig,
   output logic                    enable,
   output logic [NUM_W-1:0]        number,
   output logic [4*BCD_DIGITS-1:0] score,
   output logic [2:0]              lives,
   output logic                    correct,
   output logic                    wrong,
   output logic                    game_over,
   output logic                    logout_out
);

   state_t              state, state_d;
   logic                hard;
   logic [7:0]          round, round_d;
   logic [ADDR_W-1:0]   ptr;
   logic [NUM_W-1:0]    ans;
   logic                timed_out;
   logic [2:0]          lives_d;
   logic                session_end, start_game, capture, check_step, is_correct;

   assign rom_addr = ptr;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d    = state;
      start_game = 1'b0;
      capture    = 1'b0;
      check_step = 1'b0;
      reconfig   = 1'b0;
      enable     = 1'b0;
      correct    = 1'b0;
      wrong      = 1'b0;
      game_over  = 1'b0;
      // Leaving the session, by request or by login loss, overrides everything else.
      session_end = (state != S_IDLE) && (logout || !logged_in);
      is_correct  = !timed_out && (ans == number);
      round_d     = round + 8'd1;
      lives_d     = lives;
      if (!is_correct && hard && lives != 3'd0) lives_d = lives - 3'd1;

      case (state)
         S_IDLE:    if (logged_in) state_d = S_READY;
         S_READY:   if (game_start) begin
                       start_game = 1'b1;
                       state_d    = S_FETCH;
                    end
         S_FETCH:   state_d = S_LATCH;
         S_LATCH:   state_d = S_SHOW;
         S_SHOW:    begin
                       reconfig = 1'b1;
                       state_d  = S_WAIT_IN;
                    end
         S_WAIT_IN: begin
                       enable = 1'b1;
                       if (load || timeout) begin
                          capture = 1'b1;
                          state_d = S_CHECK;
                       end
                    end
         S_CHECK:   begin
                       check_step = 1'b1;
                       correct    = is_correct;
                       wrong      = !is_correct;
                       if (round_d == 8'(ROUNDS) || lives_d == 3'd0) state_d = S_DONE;
                       else                                            state_d = S_FETCH;
                    end
         S_DONE:    begin
                       game_over = 1'b1;
                       if (game_start) begin
                          start_game = 1'b1;
                          state_d    = S_FETCH;
                       end
                    end
         default:   state_d = S_IDLE;
      endcase

      if (session_end) begin
         state_d    = S_IDLE;
         start_game = 1'b0;
         capture    = 1'b0;
         check_step = 1'b0;
         correct    = 1'b0;
         wrong      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || session_end) begin
         hard      <= 1'b0;
         round     <= '0;
         lives     <= '0;
         ptr       <= '0;
         number    <= '0;
         ans       <= '0;
         timed_out <= 1'b0;
      end else begin
         if (start_game) begin
            hard  <= is_hard(level);
            round <= '0;
            lives <= is_hard(level) ? 3'(MAX_LIVES) : 3'd7;
            ptr   <= ADDR_W'(level_base(level, ADDR_W));
         end
         if (state == S_LATCH) number <= rom_data;
         // load wins over a simultaneous timeout.
         if (capture) begin
            ans       <= user_input;
            timed_out <= !load;
         end
         if (check_step) begin
            round <= round_d;
            lives <= lives_d;
            ptr   <= ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) logout_out <= 1'b0;
      else     logout_out <= logout && (state != S_IDLE);
   end

   bcd_score_counter #(
      .BCD_DIGITS(BCD_DIGITS)
   ) u_score (
      .clk  (clk),
      .rst  (rst),
      .clr  (session_end || start_game),
      .inc  (check_step && is_correct),
      .score(score)
   );

endmodule
